alu_share_arb: RTL and testbench

- Shares the single 32-bit ALU (alu32-style: combinational result plus zero flag, 4-bit ALU control line) between two requesters, e.g. the main datapath and a branch/address unit.
- Arbitrates round-robin and registers the operands driving the ALU.
- Captures the result one cycle later and returns it on a valid/ready response channel tagged with the requester ID.
- Screens illegal ALU control codes.

---
 rtl/alu_share_arb.sv | 164 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are registered toward the ALU; the result returns on a tagged valid/ready channel.
module alu_share_arb #(
    parameter int W  = 32,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [GW-1:0] req0_gin,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [GW-1:0] req1_gin,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [GW-1:0] alu_gin,
    input  logic [W-1:0]  alu_sum,
    input  logic          alu_zout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_sum,
    output logic          rsp_zero,
    output logic          rsp_err,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshakes: a transfer happens on the rising edge where valid && ready.
    // reqN_ready is combinational and high only in IDLE for the granted requester;
    // rsp_* are held stable while rsp_valid && !rsp_ready.

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          cur_id_q, cur_id_d;
    logic          illegal_q, illegal_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [GW-1:0] alu_gin_q, alu_gin_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [W-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_err_q, rsp_err_d;

    logic          grant1;
    logic          accept;
    logic [W-1:0]  sel_a, sel_b;
    logic [GW-1:0] sel_gin;

    function automatic logic gin_legal(input logic [GW-1:0] g);
        logic ok;
        ok = 1'b0;
        case (g)
            GW'(4'b0000), GW'(4'b0001), GW'(4'b0010), GW'(4'b0110), GW'(4'b0111),
            GW'(4'b1000), GW'(4'b1001), GW'(4'b1010), GW'(4'b1111): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == S_IDLE) && req0_valid && !grant1;
        req1_ready = (state_q == S_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel_a      = grant1 ? req1_a   : req0_a;
        sel_b      = grant1 ? req1_b   : req0_b;
        sel_gin    = grant1 ? req1_gin : req0_gin;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        illegal_d    = illegal_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_gin_d    = alu_gin_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_gin_d    = sel_gin;
                    cur_id_d     = grant1;
                    last_grant_d = grant1;
                    illegal_d    = !gin_legal(sel_gin);
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_sum_d   = illegal_q ? '0 : alu_sum;
                rsp_zero_d  = illegal_q ? 1'b0 : alu_zout;
                rsp_err_d   = illegal_q;
                rsp_id_d    = cur_id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            illegal_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_gin_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            illegal_q    <= illegal_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_gin_q    <= alu_gin_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_gin   = alu_gin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table plus hand-written contention,
// backpressure and reset sequences, with a small behavioural ALU attached.
module tb_alu_share_arb;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_gin, req1_gin;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [3:0]  alu_gin;
    logic        alu_zout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [31:0] rsp_sum;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gin;
        logic [31:0] sum;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    alu_share_arb #(.W(32), .GW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_gin(req0_gin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_gin(req1_gin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
        .alu_sum(alu_sum), .alu_zout(alu_zout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in; illegal codes produce junk with the zero flag set so masking is visible.
    always_comb begin
        alu_sum  = 32'h0;
        alu_zout = 1'b0;
        case (alu_gin)
            4'b0000: alu_sum = alu_a & alu_b;
            4'b0001: alu_sum = alu_a | alu_b;
            4'b0010: alu_sum = alu_a + alu_b;
            4'b0110: alu_sum = alu_a - alu_b;
            4'b0111: alu_sum = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1000: for (int i = 0; i < 32; i++) alu_sum[i] = alu_a[31-i];
            4'b1001: alu_sum = alu_a ^ alu_b;
            4'b1010: alu_sum = ~(alu_a | alu_b);
            4'b1111: alu_sum = alu_a;
            default: alu_sum = 32'hDEAD_BEEF;
        endcase
        alu_zout = (alu_sum == 32'h0);
        if (alu_sum == 32'hDEAD_BEEF) alu_zout = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drive_req(input logic id, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] g);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_gin = g;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_gin = g;
        end
    endtask

    task automatic clear_reqs();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic check_idle_regs(input string tag);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_busy"},      {31'b0, busy},      32'd0);
        chk({tag, "_alu_gin"},   {28'b0, alu_gin},   32'd0);
        chk({tag, "_alu_a"},     alu_a,              32'd0);
        chk({tag, "_rsp_sum"},   rsp_sum,            32'd0);
    endtask

    // Single transaction from the IDLE state with rsp_ready held high; checks every cycle.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        drive_req(v.id, 1'b1, v.a, v.b, v.gin);
        #1;
        chk("grant_ready", {30'b0, req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
        @(negedge clk);
        clear_reqs();
        #1;
        chk("exec_busy",      {31'b0, busy},      32'd1);
        chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("exec_alu_a",     alu_a,              v.a);
        chk("exec_alu_b",     alu_b,              v.b);
        chk("exec_alu_gin",   {28'b0, alu_gin},   {28'b0, v.gin});
        @(negedge clk);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_id",    {31'b0, rsp_id},    {31'b0, v.id});
        chk("rsp_sum",   rsp_sum,            v.sum);
        chk("rsp_zero",  {31'b0, rsp_zero},  {31'b0, v.zero});
        chk("rsp_err",   {31'b0, rsp_err},   {31'b0, v.err});
        @(negedge clk);
        chk("back_idle", {30'b0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd5,         32'd3,         4'b0010, 32'd8,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'd7,         32'd7,         4'b0110, 32'd0,         1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'd1,         32'd1,         4'b0011, 32'd0,         1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'd1,         4'b0111, 32'd1,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'hAAAA_0000, 32'h0000_FFFF, 4'b1010, 32'h5555_0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h1234_5678, 32'h1234_5678, 4'b1001, 32'd0,         1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_CAFE, 32'h1111_1111, 4'b1111, 32'h0000_CAFE, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd0,         32'd0,         4'b1100, 32'd0,         1'b0, 1'b1};

        reset = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_regs("reset");
        chk("reset_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Backpressure: response held for 5 cycles while requester 1 waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b0, 1'b1, 32'd10, 32'd20, 4'b0010);
        @(negedge clk);
        clear_reqs();
        drive_req(1'b1, 1'b1, 32'd9, 32'd4, 4'b0110);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_sum",   rsp_sum,            32'd30);
            chk("bp_id",    {31'b0, rsp_id},    32'd0);
            chk("bp_busy",  {31'b0, busy},      32'd1);
            chk("bp_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release", {29'b0, busy, rsp_valid, req1_ready}, 32'd1);
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        chk("bp_next_sum", rsp_sum,         32'd5);
        chk("bp_next_id",  {31'b0, rsp_id}, 32'd1);
        @(negedge clk);

        // Reset during EXEC after a requester-0 grant; the next tie must still go to 0.
        drive_req(1'b0, 1'b1, 32'd2, 32'd2, 4'b0010);
        @(negedge clk);
        clear_reqs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_regs("rst_exec");

        // Contention: both valid continuously, grants alternate 0,1,0,1 every 3 cycles.
        drive_req(1'b0, 1'b1, 32'd5, 32'd3, 4'b0010);
        drive_req(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_grant", {30'b0, req1_ready, req0_ready}, (k % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
            chk("cont_exec_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            chk("cont_rsp_id",  {31'b0, rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("cont_rsp_sum", rsp_sum,         (k % 2 == 1) ? 32'h0000_00FF : 32'd8);
            @(negedge clk);
        end
        clear_reqs();

        // Reset during a stalled RESP; then the tie again goes to requester 0.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(1'b1, 1'b1, 32'd3, 32'd4, 4'b0010);
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        check_idle_regs("rst_resp");
        drive_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
        drive_req(1'b1, 1'b1, 32'd1, 32'd1, 4'b0010);
        #1;
        chk("rst_tie", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
